pipelined_calculator: RTL and testbench

Parametrised successor of the 8-bit simple calculator: a DEPTH-entry, WIDTH-bit register file coupled to a registered ALU with a valid/ready command interface and an optional multi-cycle shift-add multiplier. Each accepted command selects operand X (register RX or DataIn) and operand Y (register RY), computes, and writes the result back to RW. It sits between the testbench/host command source and the datapath as the calculator core of the next lab stage.

---
 rtl/pipelined_calculator_if.sv | 31 +++
 rtl/pipelined_calculator.sv | 178 +++++++++++++++++
 tb/tb_pipelined_calculator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_calculator_if.sv
// Command/result bundle for pipelined_calculator.
// master: command source (drives the command, observes results).
// slave : the calculator core.
interface pipelined_calculator_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
);
   logic             In_valid;
   logic             In_ready;
   logic [AW-1:0]    RW;
   logic [AW-1:0]    RX;
   logic [AW-1:0]    RY;
   logic [WIDTH-1:0] DataIn;
   logic             Sel;
   logic [3:0]       Ctrl;
   logic             Out_valid;
   logic [WIDTH-1:0] Result;
   logic             Carry;
   logic             Zero;
   logic [WIDTH-1:0] busY;

   modport master (
      output In_valid, RW, RX, RY, DataIn, Sel, Ctrl,
      input  In_ready, Out_valid, Result, Carry, Zero, busY
   );

   modport slave (
      input  In_valid, RW, RX, RY, DataIn, Sel, Ctrl,
      output In_ready, Out_valid, Result, Carry, Zero, busY
   );
endinterface

// File: rtl/pipelined_calculator.sv
// Register-file calculator core: DEPTH x WIDTH registers feeding a registered
// ALU behind a valid/ready command port. Optional shift-add multiplier is
// built only when CALC_MUL_EN is defined; otherwise opcode 14 is reserved.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a command; single-cycle ops complete on accept
// S_MUL  | shift-add multiply in progress, one partial product per cycle
module pipelined_calculator #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   pipelined_calculator_if.slave  bus
);
   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] x, y;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_wr;
   logic             accept, commit, commit_wr;
   logic [WIDTH-1:0] commit_res;
   logic             commit_c;
   logic [AW-1:0]    commit_addr;
   logic [WIDTH-1:0] result_q;
   logic             carry_q, zero_q, out_valid_q;

   // Register 0 is hard-wired to zero on the read side.
   always_comb begin
      y = (bus.RY == '0) ? '0 : regs[bus.RY];
      x = bus.DataIn;
      if (bus.Sel) x = (bus.RX == '0) ? '0 : regs[bus.RX];
   end

   assign bus.busY = y;

`ifdef CALC_MUL_EN
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod, prod_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mcand;
   logic [AW-1:0]      mul_rw;
   logic               mul_op, mul_start, mul_last;

   assign bus.In_ready = (state == S_IDLE);
   assign mul_start    = accept && mul_op;
   assign mul_last     = (state == S_MUL) && (cnt == '0);

   // One shift-add step: add multiplicand when the current multiplier bit is set.
   always_comb begin
      mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nxt = {mul_sum, prod[WIDTH-1:1]};
   end

   // State register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (mul_start) state_nxt = S_MUL;
         S_MUL:   if (cnt == '0) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Multiplier operand latch and iteration down-counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         mul_rw <= '0;
      end else if (mul_start) begin
         cnt    <= CW'(WIDTH - 1);
         prod   <= {{WIDTH{1'b0}}, y};
         mcand  <= x;
         mul_rw <= bus.RW;
      end else if (state == S_MUL) begin
         cnt  <= cnt - CW'(1);
         prod <= prod_nxt;
      end
   end

   // Completion source: multiplier finishing, or a single-cycle accept.
   always_comb begin
      commit      = (accept && !mul_op) || mul_last;
      commit_res  = mul_last ? prod_nxt[WIDTH-1:0] : alu_res;
      commit_c    = mul_last ? |prod_nxt[2*WIDTH-1:WIDTH] : alu_c;
      commit_wr   = mul_last ? 1'b1 : alu_wr;
      commit_addr = mul_last ? mul_rw : bus.RW;
   end
`else
   assign bus.In_ready = 1'b1;

   // Every accepted command completes in the accept cycle.
   always_comb begin
      commit      = accept;
      commit_res  = alu_res;
      commit_c    = alu_c;
      commit_wr   = alu_wr;
      commit_addr = bus.RW;
   end
`endif

   assign accept = bus.In_valid && bus.In_ready;

   // Single-cycle ALU; reserved opcodes keep the previous carry and skip the write.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_wr  = 1'b1;
`ifdef CALC_MUL_EN
      mul_op  = 1'b0;
`endif
      case (bus.Ctrl)
         4'd0:  {alu_c, alu_res} = {1'b0, x} + {1'b0, y};
         4'd1:  {alu_c, alu_res} = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
         4'd2:  alu_res = x & y;
         4'd3:  alu_res = x | y;
         4'd4:  alu_res = x ^ y;
         4'd5:  alu_res = ~x;
         4'd6:  begin alu_res = {x[WIDTH-2:0], 1'b0};      alu_c = x[WIDTH-1]; end
         4'd7:  begin alu_res = {1'b0, x[WIDTH-1:1]};      alu_c = x[0];       end
         4'd8:  begin alu_res = {x[WIDTH-1], x[WIDTH-1:1]}; alu_c = x[0];      end
         4'd9:  alu_res = {x[WIDTH-2:0], x[WIDTH-1]};
         4'd10: alu_res = {x[0], x[WIDTH-1:1]};
         4'd11: alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         4'd12: alu_res = {{(WIDTH-1){1'b0}}, (x == y)};
         4'd13: alu_res = x;
`ifdef CALC_MUL_EN
         4'd14: begin alu_wr = 1'b0; mul_op = 1'b1; end
`endif
         default: begin alu_c = carry_q; alu_wr = 1'b0; end
      endcase
   end

   // Register file write-back; register 0 is never written.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (commit && commit_wr && (commit_addr != '0)) begin
         regs[commit_addr] <= commit_res;
      end
   end

   // Registered result, flags and completion pulse.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= commit;
         if (commit) begin
            result_q <= commit_res;
            carry_q  <= commit_c;
            zero_q   <= (commit_res == '0);
         end
      end
   end

   assign bus.Out_valid = out_valid_q;
   assign bus.Result    = result_q;
   assign bus.Carry     = carry_q;
   assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_pipelined_calculator.sv
// Self-checking bench for pipelined_calculator (WIDTH=8, AW=3).
module tb_pipelined_calculator;
   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   pipelined_calculator_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
   pipelined_calculator #(.WIDTH(WIDTH), .AW(AW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int tag_ctr = 0;

   typedef struct {
      logic [7:0] res;
      logic       c;
      logic       z;
      int         tag;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      logic [2:0] rw, rx, ry;
      logic [7:0] d;
      logic       sel;
      logic [3:0] ctrl;
      logic [7:0] er;
      logic       ec;
   } vec_t;
   vec_t vt [0:22];

   logic [7:0] reg_exp [0:7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every completion pulse is matched against the oldest expectation.
   always @(negedge Clk) begin
      if (Rst_n && bus.Out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got 1, want 0");
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("result[%0d]", mon_e.tag), {24'd0, bus.Result}, {24'd0, mon_e.res});
            check($sformatf("carry[%0d]", mon_e.tag), {31'd0, bus.Carry}, {31'd0, mon_e.c});
            check($sformatf("zero[%0d]", mon_e.tag), {31'd0, bus.Zero}, {31'd0, mon_e.z});
         end
      end
   end

   task automatic drive(input logic [2:0] rw, rx, ry, input logic [7:0] d,
                        input logic sel, input logic [3:0] ctrl,
                        input logic [7:0] er, input logic ec);
      exp_t e;
      bus.RW = rw; bus.RX = rx; bus.RY = ry;
      bus.DataIn = d; bus.Sel = sel; bus.Ctrl = ctrl;
      bus.In_valid = 1'b1;
      e.res = er; e.c = ec; e.z = (er == 8'h00); e.tag = tag_ctr;
      tag_ctr++;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [2:0] rw, rx, ry, input logic [7:0] d,
                        input logic sel, input logic [3:0] ctrl,
                        input logic [7:0] er, input logic ec);
      int n = 0;
      while (bus.In_ready !== 1'b1 && n < 100) begin
         @(posedge Clk); #1;
         n++;
      end
      if (n >= 100) check("in_ready_timeout", 32'd0, 32'd1);
      drive(rw, rx, ry, d, sel, ctrl, er, ec);
      @(posedge Clk); #1;
      bus.In_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_result"},    {24'd0, bus.Result},    32'h00);
      check({tag, "_carry"},     {31'd0, bus.Carry},     32'd0);
      check({tag, "_zero"},      {31'd0, bus.Zero},      32'd1);
      check({tag, "_out_valid"}, {31'd0, bus.Out_valid}, 32'd0);
      check({tag, "_in_ready"},  {31'd0, bus.In_ready},  32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        rw    rx    ry    data   sel   op     res    c
      vt = '{
         '{3'd3, 3'd0, 3'd0, 8'h5A, 1'b0, 4'd13, 8'h5A, 1'b0},   // PASS imm -> r3
         '{3'd1, 3'd0, 3'd0, 8'hF0, 1'b0, 4'd13, 8'hF0, 1'b0},   // r1 = F0
         '{3'd2, 3'd0, 3'd0, 8'h20, 1'b0, 4'd13, 8'h20, 1'b0},   // r2 = 20
         '{3'd4, 3'd1, 3'd2, 8'h00, 1'b1, 4'd0,  8'h10, 1'b1},   // ADD r1+r2
         '{3'd5, 3'd1, 3'd2, 8'h00, 1'b1, 4'd1,  8'hD0, 1'b1},   // SUB r1-r2
         '{3'd6, 3'd2, 3'd1, 8'h00, 1'b1, 4'd1,  8'h30, 1'b0},   // SUB r2-r1
         '{3'd7, 3'd1, 3'd2, 8'h00, 1'b1, 4'd2,  8'h20, 1'b0},   // AND
         '{3'd0, 3'd0, 3'd2, 8'h0F, 1'b0, 4'd3,  8'h2F, 1'b0},   // OR
         '{3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 4'd4,  8'hD0, 1'b0},   // XOR
         '{3'd0, 3'd0, 3'd0, 8'h0F, 1'b0, 4'd5,  8'hF0, 1'b0},   // NOT
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd6,  8'h02, 1'b1},   // SLL
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd7,  8'h40, 1'b1},   // SRL
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd8,  8'hC0, 1'b1},   // SRA
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd9,  8'h03, 1'b0},   // ROL
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd10, 8'hC0, 1'b0},   // ROR
         '{3'd0, 3'd0, 3'd2, 8'h81, 1'b0, 4'd11, 8'h01, 1'b0},   // -127 < 32
         '{3'd0, 3'd2, 3'd1, 8'h00, 1'b1, 4'd11, 8'h00, 1'b0},   // 32 < -16 false
         '{3'd0, 3'd0, 3'd2, 8'h20, 1'b0, 4'd12, 8'h01, 1'b0},   // EQ true
         '{3'd0, 3'd0, 3'd2, 8'h21, 1'b0, 4'd12, 8'h00, 1'b0},   // EQ false
         '{3'd0, 3'd0, 3'd1, 8'h10, 1'b0, 4'd0,  8'h00, 1'b1},   // ADD wraps to 0
         '{3'd3, 3'd0, 3'd0, 8'h77, 1'b0, 4'd15, 8'h00, 1'b1},   // reserved, carry held
         '{3'd0, 3'd3, 3'd0, 8'h00, 1'b1, 4'd13, 8'h5A, 1'b0},   // r3 untouched
         '{3'd0, 3'd0, 3'd0, 8'h81, 1'b0, 4'd13, 8'h81, 1'b0}    // PASS to r0
      };
      reg_exp = '{8'h00, 8'hF0, 8'h20, 8'h5A, 8'h10, 8'hD0, 8'h30, 8'h20};

      bus.In_valid = 1'b0; bus.RW = '0; bus.RX = '0; bus.RY = '0;
      bus.DataIn = '0; bus.Sel = 1'b0; bus.Ctrl = '0;

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_reset_outputs("in_reset");
      Rst_n = 1'b1;
      @(negedge Clk);
      check_reset_outputs("post_reset");
      @(posedge Clk); #1;

      // Vector table, issued back to back.
      for (int i = 0; i < 23; i++)
         issue(vt[i].rw, vt[i].rx, vt[i].ry, vt[i].d, vt[i].sel, vt[i].ctrl, vt[i].er, vt[i].ec);
      repeat (2) @(negedge Clk);

      // Register file contents via the combinational Y read port.
      for (int r = 0; r < 8; r++) begin
         bus.RY = 3'(r);
         #1;
         check($sformatf("regfile_r%0d", r), {24'd0, bus.busY}, {24'd0, reg_exp[r]});
      end

      // busY shows the old value in the accept cycle, the new one after.
      @(posedge Clk); #1;
      drive(3'd3, 3'd0, 3'd3, 8'h77, 1'b0, 4'd13, 8'h77, 1'b0);
      #1;
      check("busy_prewrite", {24'd0, bus.busY}, 32'h5A);
      @(posedge Clk); #1;
      bus.In_valid = 1'b0;
      check("busy_postwrite", {24'd0, bus.busY}, 32'h77);

      // Back-to-back dependent commands.
      issue(3'd1, 3'd0, 3'd0, 8'h07, 1'b0, 4'd13, 8'h07, 1'b0);
      @(negedge Clk);
      check("b2b_first_valid", {31'd0, bus.Out_valid}, 32'd1);
      issue(3'd2, 3'd1, 3'd1, 8'h00, 1'b1, 4'd0, 8'h0E, 1'b0);
      @(negedge Clk);
      check("b2b_second_valid", {31'd0, bus.Out_valid}, 32'd1);
      bus.RY = 3'd2;
      #1;
      check("b2b_r2", {24'd0, bus.busY}, 32'h0E);
      @(negedge Clk);
      check("b2b_single_pulse", {31'd0, bus.Out_valid}, 32'd0);

`ifdef CALC_MUL_EN
      issue(3'd5, 3'd0, 3'd0, 8'h11, 1'b0, 4'd13, 8'h11, 1'b0);
      issue(3'd6, 3'd0, 3'd5, 8'h10, 1'b0, 4'd14, 8'h10, 1'b1);
      for (int c = 0; c < 8; c++) begin
         @(negedge Clk);
         check($sformatf("mul_busy_ready_c%0d", c), {31'd0, bus.In_ready}, 32'd0);
         check($sformatf("mul_busy_valid_c%0d", c), {31'd0, bus.Out_valid}, 32'd0);
      end
      @(negedge Clk);
      check("mul_done_ready", {31'd0, bus.In_ready}, 32'd1);
      check("mul_done_valid", {31'd0, bus.Out_valid}, 32'd1);
      @(posedge Clk); #1;
      issue(3'd4, 3'd0, 3'd0, 8'h05, 1'b0, 4'd13, 8'h05, 1'b0);
      issue(3'd7, 3'd0, 3'd4, 8'h03, 1'b0, 4'd14, 8'h0F, 1'b0);
      repeat (10) @(negedge Clk);
      bus.RY = 3'd6; #1;
      check("mul_r6", {24'd0, bus.busY}, 32'h10);
      bus.RY = 3'd7; #1;
      check("mul_r7", {24'd0, bus.busY}, 32'h0F);

      // Reset three cycles into a multiply aborts it.
      @(posedge Clk); #1;
      issue(3'd3, 3'd0, 3'd4, 8'h02, 1'b0, 4'd14, 8'h0A, 1'b0);
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      check_reset_outputs("mul_abort_in_reset");
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge Clk);
         check($sformatf("abort_no_valid_c%0d", c), {31'd0, bus.Out_valid}, 32'd0);
      end
      check("abort_in_ready", {31'd0, bus.In_ready}, 32'd1);
      bus.RY = 3'd3; #1;
      check("abort_no_write", {24'd0, bus.busY}, 32'h00);
`else
      // Without the multiplier, opcode 14 is reserved and single-cycle.
      issue(3'd0, 3'd0, 3'd1, 8'hFF, 1'b0, 4'd0, 8'h06, 1'b1);
      issue(3'd5, 3'd0, 3'd0, 8'h11, 1'b0, 4'd14, 8'h00, 1'b1);
      check("op14_in_ready", {31'd0, bus.In_ready}, 32'd1);
      @(negedge Clk);
      bus.RY = 3'd5; #1;
      check("op14_no_write", {24'd0, bus.busY}, 32'hD0);

      // Reset mid-run returns everything to the reset state.
      @(posedge Clk); #1;
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_in_reset");
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      check_reset_outputs("rst_released");
      check("rst_regfile", {24'd0, bus.busY}, 32'h00);
`endif

      repeat (3) @(negedge Clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
